// File: rtl/tm1638_types.sv
// Shared command bytes, writer state encoding and control-byte helper for the
// TM1638 frame writer.
package tm1638_types;

  localparam logic [7:0] CMD_DATA_AUTO  = 8'h40;
  localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;
  localparam logic [7:0] CMD_CTRL       = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_CMD,
    ST_ADDR_CMD,
    ST_PAYLOAD,
    ST_CTRL_CMD
  } writer_state_e;

  function automatic logic [7:0] make_ctrl(input logic on, input logic [2:0] brightness);
    return CMD_CTRL | {4'b0000, on, brightness};
  endfunction

endpackage

// File: rtl/tm1638_payload_mux.sv
// Selects the display-RAM byte at a given address from the latched snapshot:
// even addresses carry a grid's segments, odd addresses its LED in bit 0.
module tm1638_payload_mux #(
  parameter int NUM_GRIDS = 8,
  parameter int SEG_W     = 8,
  parameter int ADDR_W    = 4
) (
  input  logic [NUM_GRIDS*SEG_W-1:0] i_Segments,
  input  logic [NUM_GRIDS-1:0]       i_Leds,
  input  logic [ADDR_W-1:0]          i_Addr,
  output logic [7:0]                 o_Byte
);

  logic [ADDR_W-1:0] w_Grid;
  logic [SEG_W-1:0]  w_Seg;
  logic              w_Led;

  assign w_Grid = i_Addr >> 1;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_Seg = '0;
    w_Led = 1'b0;
    for (int g = 0; g < NUM_GRIDS; g++) begin
      if (w_Grid == ADDR_W'(g)) begin
        w_Seg = i_Segments[g*SEG_W +: SEG_W];
        w_Led = i_Leds[g];
      end
    end
  end

  always_comb begin
    o_Byte = '0;
    if (i_Addr[0]) o_Byte[0] = w_Led;
    else           o_Byte[SEG_W-1:0] = w_Seg;
  end

endmodule

// File: rtl/tm1638_frame_writer.sv
// Serialises a snapshot of NUM_GRIDS grids plus LEDs into TM1638 command
// frames pushed byte-by-byte into the SPI transmit FIFO.
module tm1638_frame_writer
  import tm1638_types::*;
#(
  parameter int NUM_GRIDS = 8,
  parameter bit AUTO_INC  = 1'b1,
  parameter int SEG_W     = 8
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [NUM_GRIDS*SEG_W-1:0] i_Segments,
  input  logic [NUM_GRIDS-1:0]       i_Leds,
  input  logic [2:0]                 i_Brightness,
  input  logic                       i_Display_On,
  input  logic                       i_Valid,
  input  logic                       i_SPI_FIFO_Full,
  output logic [7:0]                 o_Data,
  output logic                       o_Last,
  output logic                       o_Write,
  output logic                       o_Busy,
  output logic                       o_Done
);

  localparam int ADDR_W = ($clog2(2*NUM_GRIDS) > 1) ? $clog2(2*NUM_GRIDS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2*NUM_GRIDS-1);

  writer_state_e r_State, w_Next;

  logic [ADDR_W-1:0]          r_Addr;
  logic [NUM_GRIDS*SEG_W-1:0] r_Segments;
  logic [NUM_GRIDS-1:0]       r_Leds;
  logic [2:0]                 r_Brightness;
  logic                       r_On;
  logic                       r_Pending;
  logic                       r_Done;

  logic       w_Push;
  logic       w_Final;
  logic       w_Snap;
  logic [7:0] w_Payload;

  assign w_Push  = (r_State != ST_IDLE) && !i_SPI_FIFO_Full;
  assign w_Final = (r_Addr == LAST_ADDR);
  // A pending (or coincident) request restarts straight from the control push.
  assign w_Snap  = ((r_State == ST_IDLE) && i_Valid) ||
                   ((r_State == ST_CTRL_CMD) && w_Push && (r_Pending || i_Valid));

  tm1638_payload_mux #(
    .NUM_GRIDS (NUM_GRIDS),
    .SEG_W     (SEG_W),
    .ADDR_W    (ADDR_W)
  ) u_payload_mux (
    .i_Segments (r_Segments),
    .i_Leds     (r_Leds),
    .i_Addr     (r_Addr),
    .o_Byte     (w_Payload)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= ST_IDLE;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      ST_IDLE:     if (i_Valid) w_Next = ST_DATA_CMD;
      ST_DATA_CMD: if (w_Push) w_Next = ST_ADDR_CMD;
      ST_ADDR_CMD: if (w_Push) w_Next = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (w_Push) begin
          if (w_Final)        w_Next = ST_CTRL_CMD;
          else if (!AUTO_INC) w_Next = ST_ADDR_CMD;
        end
      end
      ST_CTRL_CMD: if (w_Push) w_Next = w_Snap ? ST_DATA_CMD : ST_IDLE;
      default:     w_Next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Addr       <= '0;
      r_Segments   <= '0;
      r_Leds       <= '0;
      r_Brightness <= '0;
      r_On         <= 1'b0;
      r_Pending    <= 1'b0;
      r_Done       <= 1'b0;
    end else begin
      r_Done <= (r_State == ST_CTRL_CMD) && w_Push;
      if (w_Snap) begin
        r_Segments   <= i_Segments;
        r_Leds       <= i_Leds;
        r_Brightness <= i_Brightness;
        r_On         <= i_Display_On;
        r_Pending    <= 1'b0;
      end else if (i_Valid && (r_State != ST_IDLE)) begin
        r_Pending <= 1'b1;
      end
      if ((r_State == ST_DATA_CMD) && w_Push)
        r_Addr <= '0;
      else if ((r_State == ST_PAYLOAD) && w_Push && !w_Final)
        r_Addr <= r_Addr + ADDR_W'(1);
    end
  end

  always_comb begin
    o_Data = '0;
    o_Last = 1'b0;
    case (r_State)
      ST_DATA_CMD: begin
        o_Data = AUTO_INC ? CMD_DATA_AUTO : CMD_DATA_FIXED;
        o_Last = 1'b1;
      end
      ST_ADDR_CMD: o_Data = CMD_ADDR | 8'(r_Addr);
      ST_PAYLOAD: begin
        o_Data = w_Payload;
        o_Last = AUTO_INC ? w_Final : 1'b1;
      end
      ST_CTRL_CMD: begin
        o_Data = make_ctrl(r_On, r_Brightness);
        o_Last = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_Write = w_Push;
  assign o_Busy  = (r_State != ST_IDLE) || r_Pending;
  assign o_Done  = r_Done;

endmodule

// File: tb/tb_tm1638_frame_writer.sv
// Scoreboard bench for three frame-writer configurations: 8 grids burst,
// 2 grids fixed-address, 1 grid with 7-bit segments.
module tb_tm1638_frame_writer;

  typedef struct {
    logic [7:0] d;
    logic       l;
    bit         eor;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] seg   [3];
  logic [7:0]  leds  [3];
  logic [2:0]  bri   [3];
  logic        on_   [3];
  logic        valid [3];
  logic        full  [3];
  logic [7:0]  data  [3];
  logic        last  [3];
  logic        wr    [3];
  logic        busy  [3];
  logic        done  [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   [3];
  bit   pend     [3];
  bit   done_exp [3];
  exp_t exp_q    [3][$];
  bit   rand_full = 0;

  tm1638_frame_writer #(.NUM_GRIDS(8), .AUTO_INC(1'b1), .SEG_W(8)) u_dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg[0]), .i_Leds(leds[0]),
    .i_Brightness(bri[0]), .i_Display_On(on_[0]), .i_Valid(valid[0]),
    .i_SPI_FIFO_Full(full[0]), .o_Data(data[0]), .o_Last(last[0]),
    .o_Write(wr[0]), .o_Busy(busy[0]), .o_Done(done[0]));

  tm1638_frame_writer #(.NUM_GRIDS(2), .AUTO_INC(1'b0), .SEG_W(8)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg[1][15:0]), .i_Leds(leds[1][1:0]),
    .i_Brightness(bri[1]), .i_Display_On(on_[1]), .i_Valid(valid[1]),
    .i_SPI_FIFO_Full(full[1]), .o_Data(data[1]), .o_Last(last[1]),
    .o_Write(wr[1]), .o_Busy(busy[1]), .o_Done(done[1]));

  tm1638_frame_writer #(.NUM_GRIDS(1), .AUTO_INC(1'b1), .SEG_W(7)) u_dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_Segments(seg[2][6:0]), .i_Leds(leds[2][0:0]),
    .i_Brightness(bri[2]), .i_Display_On(on_[2]), .i_Valid(valid[2]),
    .i_SPI_FIFO_Full(full[2]), .o_Data(data[2]), .o_Last(last[2]),
    .o_Write(wr[2]), .o_Busy(busy[2]), .o_Done(done[2]));

  function automatic int cfg_grids(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 1;
  endfunction

  function automatic bit cfg_auto(input int k);
    return (k != 1);
  endfunction

  function automatic int cfg_segw(input int k);
    return (k == 2) ? 7 : 8;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int k, input logic [7:0] d, input logic l,
                                   input bit eor);
    exp_t e;
    e.d = d;
    e.l = l;
    e.eor = eor;
    exp_q[k].push_back(e);
  endfunction

  // Reference frame built from the current inputs of instance k.
  function automatic void build_frame(input int k);
    int         n  = cfg_grids(k);
    bit         ai = cfg_auto(k);
    int         sw = cfg_segw(k);
    logic [63:0] mask = (64'd1 << sw) - 64'd1;
    logic [7:0] p;
    push_exp(k, ai ? 8'h40 : 8'h44, 1'b1, 1'b0);
    if (ai) push_exp(k, 8'hC0, 1'b0, 1'b0);
    for (int a = 0; a < 2*n; a++) begin
      if (!ai) push_exp(k, 8'(8'hC0 + a), 1'b0, 1'b0);
      if (a % 2 == 0) p = 8'((seg[k] >> ((a/2)*sw)) & mask);
      else            p = 8'((leds[k] >> (a/2)) & 8'd1);
      push_exp(k, p, ai ? (a == 2*n-1) : 1'b1, 1'b0);
    end
    push_exp(k, 8'(8'h80 + 8*on_[k] + bri[k]), 1'b1, 1'b1);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   eor;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        exp_q[k].delete();
        pend[k] = 0;
        done_exp[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        eor = 0;
        check(done[k] === done_exp[k], $sformatf("done%0d", k), 32'(done[k]),
              32'(done_exp[k]));
        if (valid[k]) begin
          if (exp_q[k].size() == 0) build_frame(k);
          else                      pend[k] = 1;
        end
        if (wr[k]) begin
          wr_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            check(0, $sformatf("unexpected_write%0d", k), 32'(data[k]), 0);
          end else begin
            e = exp_q[k].pop_front();
            check({last[k], data[k]} === {e.l, e.d}, $sformatf("byte%0d", k),
                  32'({last[k], data[k]}), 32'({e.l, e.d}));
            eor = e.eor;
          end
        end
        if (eor && pend[k]) begin
          pend[k] = 0;
          build_frame(k);
        end
        done_exp[k] = eor;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_full)
        for (int k = 0; k < 3; k++) full[k] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic request(input int k);
    valid[k] = 1'b1;
    tick(1);
    valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int c = 0;
    while ((exp_q[k].size() != 0 || pend[k]) && c < budget) begin
      tick(1);
      c++;
    end
    check(c < budget, $sformatf("idle_timeout%0d", k), c, budget);
    check(busy[k] == 1'b0, $sformatf("busy_idle%0d", k), 32'(busy[k]), 0);
  endtask

  task automatic wait_writes(input int k, input int target, input int budget);
    int c = 0;
    while (wr_cnt[k] < target && c < budget) begin
      tick(1);
      c++;
    end
    check(c < budget, $sformatf("write_timeout%0d", k), wr_cnt[k], target);
  endtask

  task automatic check_reset_outputs(input int k);
    check({data[k], last[k], wr[k], busy[k], done[k]} == '0,
          $sformatf("reset_outputs%0d", k),
          32'({data[k], last[k], wr[k], busy[k], done[k]}), 0);
  endtask

  task automatic rand_inputs(input int k);
    seg[k]  = {$urandom, $urandom};
    leds[k] = 8'($urandom);
    bri[k]  = 3'($urandom);
    on_[k]  = 1'($urandom);
  endtask

  initial begin
    int base;
    int k;
    int c;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seg[i] = '0; leds[i] = '0; bri[i] = '0; on_[i] = 1'b0;
      valid[i] = 1'b0; full[i] = 1'b0; wr_cnt[i] = 0;
    end
    tick(2);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    rst = 1'b0;
    tick(2);

    // 8-grid burst frame with known pattern
    for (int g = 0; g < 8; g++) seg[0][g*8 +: 8] = 8'(8'h10 + g);
    leds[0] = 8'hA5; bri[0] = 3'd7; on_[0] = 1'b1;
    base = wr_cnt[0];
    request(0);
    wait_idle(0, 200);
    check(wr_cnt[0] - base == 19, "burst_len", wr_cnt[0] - base, 19);

    // 2-grid fixed-address frames
    seg[1] = 64'h063F; leds[1] = 8'b10; bri[1] = 3'd2; on_[1] = 1'b0;
    base = wr_cnt[1];
    request(1);
    wait_idle(1, 200);
    check(wr_cnt[1] - base == 10, "fixed_len", wr_cnt[1] - base, 10);

    // single grid, 7-bit segments
    seg[2] = 64'h7F; leds[2] = 8'h0; bri[2] = 3'd4; on_[2] = 1'b1;
    base = wr_cnt[2];
    request(2);
    wait_idle(2, 200);
    check(wr_cnt[2] - base == 5, "single_len", wr_cnt[2] - base, 5);

    // FIFO full held for 5 cycles at the 3rd byte
    rand_inputs(0);
    base = wr_cnt[0];
    request(0);
    wait_writes(0, base + 2, 100);
    full[0] = 1'b1;
    @(negedge clk);
    begin
      logic [7:0] held;
      held = data[0];
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        check(wr[0] == 1'b0, "full_write", 32'(wr[0]), 0);
        check(data[0] == held, "full_stable", 32'(data[0]), 32'(held));
      end
    end
    @(posedge clk);
    #1 full[0] = 1'b0;
    wait_idle(0, 200);
    check(wr_cnt[0] - base == 19, "full_len", wr_cnt[0] - base, 19);

    // three coalesced requests mid-frame carrying 0xFF
    rand_inputs(0);
    base = wr_cnt[0];
    request(0);
    tick(5);
    seg[0] = '1; leds[0] = 8'hFF;
    request(0);
    tick(3);
    request(0);
    tick(2);
    request(0);
    c = 0;
    while ((exp_q[0].size() != 0 || pend[0]) && c < 300) begin
      check(busy[0] == 1'b1, "busy_join", 32'(busy[0]), 1);
      tick(1);
      c++;
    end
    check(c < 300, "coalesce_timeout", c, 300);
    check(wr_cnt[0] - base == 38, "coalesce_len", wr_cnt[0] - base, 38);

    // reset during payload, then a clean frame
    rand_inputs(0);
    base = wr_cnt[0];
    request(0);
    wait_writes(0, base + 4, 100);
    #3 rst = 1'b1;
    #1 check_reset_outputs(0);
    tick(2);
    rst = 1'b0;
    tick(1);
    base = wr_cnt[0];
    request(0);
    wait_idle(0, 200);
    check(wr_cnt[0] - base == 19, "post_reset_len", wr_cnt[0] - base, 19);

    // randomized requests with random FIFO back-pressure
    rand_full = 1;
    repeat (60) begin
      k = $urandom_range(0, 2);
      c = 0;
      while (pend[k] && c < 300) begin
        tick(1);
        c++;
      end
      check(c < 300, "pend_timeout", c, 300);
      rand_inputs(k);
      request(k);
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(0, 3));
        request(k);
      end
      tick($urandom_range(0, 25));
    end
    rand_full = 0;
    for (int i = 0; i < 3; i++) full[i] = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) wait_idle(i, 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
